// File: rtl/card_draw_ctrl.sv
// card_draw_ctrl: card sprite RAM read addressing, colour keying
// and a loader write port that only opens during vertical blanking.
module card_draw_ctrl #(
   parameter logic [8:0] V_ACTIVE  = 9'd240,
   parameter logic [2:0] KEY_COLOR = 3'b000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [8:0] hcount,
   input  logic [8:0] vcount,
   input  logic       active,
   input  logic [7:0] card_x,
   input  logic [7:0] card_y,
   input  logic       card_en,
   input  logic       ld_valid,
   input  logic [8:0] ld_addr,
   input  logic [2:0] ld_data,
   output logic       ld_ready,
   output logic       ram_we,
   output logic       ram_re,
   output logic [8:0] ram_waddr,
   output logic [2:0] ram_wdata,
   output logic [8:0] ram_raddr,
   input  logic [2:0] ram_rdata,
   output logic [2:0] pix_color,
   output logic       pix_hit
);

   typedef enum logic {
      DISPLAY = 1'b0,
      VBLANK  = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] sx_q, sx_d;
   logic [7:0] sy_q, sy_d;
   logic       sen_q, sen_d;
   logic       hit1_q, hit1_d;
   logic [8:0] raddr_q, raddr_d;
   logic       hit2_q, hit2_d;
   logic       we_q, we_d;
   logic [8:0] waddr_q, waddr_d;
   logic [2:0] wdata_q, wdata_d;
   logic       pix_hit_q, pix_hit_d;
   logic [2:0] pix_color_q, pix_color_d;

   logic       enter_vb;
   logic       accept;
   logic [9:0] h_ext, v_ext, x_lo, y_lo;
   logic       opaque;

   assign ld_ready  = (state_q == VBLANK) && !reset;
   assign accept    = ld_valid && ld_ready;
   assign ram_we    = we_q;
   assign ram_waddr = waddr_q;
   assign ram_wdata = wdata_q;
   assign ram_re    = hit1_q;
   assign ram_raddr = raddr_q;
   assign pix_hit   = pix_hit_q;
   assign pix_color = pix_color_q;

   // Frame phase: display until the first blank line, blank until line 0.
   always_comb begin
      state_d  = state_q;
      enter_vb = 1'b0;
      unique case (state_q)
         DISPLAY: begin
            if (vcount == V_ACTIVE) begin
               state_d  = VBLANK;
               enter_vb = 1'b1;
            end
         end
         VBLANK: begin
            if (vcount == 9'd0) state_d = DISPLAY;
         end
         default: state_d = DISPLAY;
      endcase
   end

   // Shadow latch, hit test, read pipeline, keying and write register.
   always_comb begin
      sx_d  = sx_q;
      sy_d  = sy_q;
      sen_d = sen_q;
      if (enter_vb) begin
         sx_d  = card_x;
         sy_d  = card_y;
         sen_d = card_en;
      end

      h_ext = {1'b0, hcount};
      v_ext = {1'b0, vcount};
      x_lo  = {2'b00, sx_q};
      y_lo  = {2'b00, sy_q};

      hit1_d = active && sen_q
             && (h_ext >= x_lo) && (h_ext < x_lo + 10'd16)
             && (v_ext >= y_lo) && (v_ext < y_lo + 10'd32);
      raddr_d = {vcount[4:0] - sy_q[4:0], hcount[3:0] - sx_q[3:0]};

      hit2_d = hit1_q;

      opaque      = hit2_q && (ram_rdata != KEY_COLOR);
      pix_hit_d   = opaque;
      pix_color_d = opaque ? ram_rdata : KEY_COLOR;

      we_d    = accept;
      waddr_d = accept ? ld_addr : waddr_q;
      wdata_d = accept ? ld_data : wdata_q;
   end

   // Frame phase register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= DISPLAY;
      else       state_q <= state_d;
   end

   // Shadows, pixel pipeline and loader write registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sx_q        <= 8'd0;
         sy_q        <= 8'd0;
         sen_q       <= 1'b0;
         hit1_q      <= 1'b0;
         raddr_q     <= 9'd0;
         hit2_q      <= 1'b0;
         we_q        <= 1'b0;
         waddr_q     <= 9'd0;
         wdata_q     <= 3'd0;
         pix_hit_q   <= 1'b0;
         pix_color_q <= KEY_COLOR;
      end else begin
         sx_q        <= sx_d;
         sy_q        <= sy_d;
         sen_q       <= sen_d;
         hit1_q      <= hit1_d;
         raddr_q     <= raddr_d;
         hit2_q      <= hit2_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         pix_hit_q   <= pix_hit_d;
         pix_color_q <= pix_color_d;
      end
   end

endmodule

// File: tb/tb_card_draw_ctrl.sv
// tb_card_draw_ctrl: directed table plus randomized frames against a
// pixel/loader reference model and a behavioural card RAM.
module tb_card_draw_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic [8:0] hcount, vcount;
   logic       active;
   logic [7:0] card_x, card_y;
   logic       card_en;
   logic       ld_valid;
   logic [8:0] ld_addr;
   logic [2:0] ld_data;
   logic       ld_ready, ram_we, ram_re;
   logic [8:0] ram_waddr, ram_raddr;
   logic [2:0] ram_wdata, ram_rdata;
   logic [2:0] pix_color;
   logic       pix_hit;

   card_draw_ctrl dut (
      .clock(clock), .reset(reset),
      .hcount(hcount), .vcount(vcount), .active(active),
      .card_x(card_x), .card_y(card_y), .card_en(card_en),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_ready(ld_ready), .ram_we(ram_we), .ram_re(ram_re),
      .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
      .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
      .pix_color(pix_color), .pix_hit(pix_hit)
   );

   always #5 clock = ~clock;

   // Expected RAM contents as the loader intends them.
   logic [2:0] ref_mem [512];
   bit         preload;

   // Physical card RAM driven only by the DUT ports.
   logic [2:0] ram [512];
   always @(posedge clock) begin
      if (preload) begin
         for (int i = 0; i < 512; i++) ram[i] <= ref_mem[i];
      end else begin
         if (ram_we) ram[ram_waddr] <= ram_wdata;
         if (ram_re) ram_rdata <= ram[ram_raddr];
      end
   end

   typedef struct {
      bit hit;
      int addr;
      bit ph;
      int col;
   } ent_t;

   typedef struct {
      int hc;
      int vc;
      bit act;
      bit re;
      int addr;
      bit ph;
      int col;
   } vec_t;

   typedef struct {
      int a;
      int d;
   } wr_t;

   ent_t q[$];
   wr_t  wq[$];
   vec_t tbl[8];

   int checks = 0;
   int errors = 0;
   bit m_vb, m_sen, last_acc;
   int m_sx, m_sy;
   int cyc_n = 0;
   int we_cnt, we_first, we_last;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, got, exp);
      end
   endtask

   // One pixel clock: predict from the current inputs, clock, compare.
   task automatic cyc();
      ent_t e;
      bit   acc, vb_n, lat;
      int   a, wa, wd, hc, vc;
      hc  = int'(hcount);
      vc  = int'(vcount);
      acc = ld_valid && m_vb;
      e.hit = active && m_sen && hc >= m_sx && hc < m_sx + 16
              && vc >= m_sy && vc < m_sy + 32;
      a = ((vc - m_sy) & 31) * 16 + ((hc - m_sx) & 15);
      e.addr = a;
      e.col  = e.hit ? int'(ref_mem[a]) : 0;
      e.ph   = (e.col != 0);
      lat  = !m_vb && vc == 240;
      vb_n = m_vb ? (vc != 0) : (vc == 240);
      wa = int'(ld_addr);
      wd = int'(ld_data);
      if (acc) ref_mem[wa] = ld_data;
      @(posedge clock);
      #1;
      cyc_n++;
      m_vb = vb_n;
      if (lat) begin
         m_sx  = int'(card_x);
         m_sy  = int'(card_y);
         m_sen = card_en;
      end
      last_acc = acc;
      q.push_back(e);
      chk("ld_ready", ld_ready, m_vb);
      chk("ram_we", ram_we, acc);
      if (acc) begin
         chk("ram_waddr", ram_waddr, wa);
         chk("ram_wdata", ram_wdata, wd);
      end
      chk("ram_re", ram_re, e.hit);
      if (e.hit) chk("ram_raddr", ram_raddr, a);
      if (q.size() == 3) begin
         chk("pix_hit", pix_hit, q[0].ph);
         chk("pix_color", pix_color, q[0].col);
         void'(q.pop_front());
      end
      if (ram_we) begin
         if (we_cnt == 0) we_first = cyc_n;
         we_last = cyc_n;
         we_cnt++;
      end
   endtask

   task automatic set_px(input int hc, input int vc, input bit act);
      hcount = 9'(hc);
      vcount = 9'(vc);
      active = act;
   endtask

   task automatic idle();
      set_px(300, 5, 1'b0);
      cyc();
   endtask

   task automatic drive_ld();
      if (wq.size() > 0) begin
         ld_valid = 1'b1;
         ld_addr  = 9'(wq[0].a);
         ld_data  = 3'(wq[0].d);
      end else begin
         ld_valid = 1'b0;
      end
   endtask

   task automatic pop_ld();
      if (last_acc && wq.size() > 0) void'(wq.pop_front());
   endtask

   task automatic vblank(input int n);
      set_px(300, 240, 1'b0);
      drive_ld();
      cyc();
      pop_ld();
      for (int i = 0; i < n; i++) begin
         vcount = 9'(241 + i);
         drive_ld();
         cyc();
         pop_ld();
      end
      vcount = 9'd0;
      drive_ld();
      cyc();
      pop_ld();
      ld_valid = 1'b0;
      wq.delete();
   endtask

   task automatic probe(input int hc, input int vc, input bit exp,
                        input string nm);
      set_px(hc, vc, hc < 256 && vc < 240);
      cyc();
      idle();
      idle();
      chk(nm, pix_hit, exp);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{10, 20, 1'b1, 1'b1, 0, 1'b1, 5};
      tbl[1] = '{25, 51, 1'b1, 1'b1, 511, 1'b1, 6};
      tbl[2] = '{26, 51, 1'b1, 1'b0, 0, 1'b0, 0};
      tbl[3] = '{25, 52, 1'b1, 1'b0, 0, 1'b0, 0};
      tbl[4] = '{11, 21, 1'b1, 1'b1, 17, 1'b0, 0};
      tbl[5] = '{9, 20, 1'b1, 1'b0, 0, 1'b0, 0};
      tbl[6] = '{10, 20, 1'b0, 1'b0, 0, 1'b0, 0};
      tbl[7] = '{15, 30, 1'b1, 1'b1, 165, 1'b1, 2};

      for (int i = 0; i < 512; i++) ref_mem[i] = 3'($urandom);
      ref_mem[0]   = 3'b101;
      ref_mem[511] = 3'b110;
      ref_mem[17]  = 3'b000;
      ref_mem[165] = 3'b010;
      ref_mem[320] = 3'b111;
      ref_mem[85]  = 3'b011;

      m_vb = 0; m_sen = 0; m_sx = 0; m_sy = 0; last_acc = 0;
      we_cnt = 0; we_first = 0; we_last = 0;
      reset = 1'b1;
      preload = 1'b1;
      set_px(300, 5, 1'b0);
      card_x = 8'd10; card_y = 8'd20; card_en = 1'b1;
      ld_valid = 1'b0; ld_addr = 9'd0; ld_data = 3'd0;
      repeat (2) @(posedge clock);
      #1;
      preload = 1'b0;
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_re", ram_re, 0);
      chk("rst_waddr", ram_waddr, 0);
      chk("rst_wdata", ram_wdata, 0);
      chk("rst_raddr", ram_raddr, 0);
      chk("rst_pix_color", pix_color, 0);
      chk("rst_pix_hit", pix_hit, 0);
      @(negedge clock);
      reset = 1'b0;

      // nothing drawn before the first latch
      probe(10, 20, 1'b0, "pre_latch");
      vblank(4);

      // basic draw, edges and keying
      for (int i = 0; i < 8; i++) begin
         set_px(tbl[i].hc, tbl[i].vc, tbl[i].act);
         cyc();
         chk("tbl_re", ram_re, tbl[i].re);
         if (tbl[i].re) chk("tbl_raddr", ram_raddr, tbl[i].addr);
         idle();
         idle();
         chk("tbl_pix_hit", pix_hit, tbl[i].ph);
         chk("tbl_pix_color", pix_color, tbl[i].col);
      end

      // tear-free position update
      card_x = 8'd10; card_y = 8'd100;
      vblank(3);
      card_x = 8'd100;
      probe(10, 120, 1'b1, "tear_old_hit");
      probe(100, 120, 1'b0, "tear_new_miss");
      vblank(3);
      probe(100, 120, 1'b1, "tear_new_hit");
      probe(10, 120, 1'b0, "tear_old_miss");

      // loader gated outside vblank
      ld_valid = 1'b1; ld_addr = 9'd7; ld_data = 3'b011;
      for (int i = 0; i < 4; i++) begin
         set_px(300, 100, 1'b0);
         cyc();
      end
      chk("gate_ready", ld_ready, 0);
      chk("gate_we", ram_we, 0);
      we_cnt = 0;
      wq.push_back('{7, 3});
      vblank(4);
      chk("gate_we_count", we_cnt, 1);

      // 16-beat burst
      we_cnt = 0;
      for (int i = 0; i < 16; i++) wq.push_back('{100 + i, int'($urandom_range(0, 7))});
      vblank(20);
      chk("burst_count", we_cnt, 16);
      chk("burst_span", we_last - we_first, 15);

      // right clip
      card_x = 8'd250; card_y = 8'd0; card_en = 1'b1;
      vblank(2);
      probe(250, 0, 1'b1, "clip_left");
      probe(255, 5, 1'b1, "clip_255");
      probe(256, 5, 1'b0, "clip_256");
      probe(0, 5, 1'b0, "clip_nowrap0");
      probe(9, 0, 1'b0, "clip_nowrap9");

      // async reset with a hit in flight and the loader waiting
      ld_valid = 1'b1; ld_addr = 9'd200; ld_data = 3'b101;
      set_px(250, 0, 1'b1);
      cyc();
      idle();
      idle();
      chk("arst_pre_hit", pix_hit, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_ld_ready", ld_ready, 0);
      chk("arst_ram_we", ram_we, 0);
      chk("arst_ram_re", ram_re, 0);
      chk("arst_waddr", ram_waddr, 0);
      chk("arst_wdata", ram_wdata, 0);
      chk("arst_raddr", ram_raddr, 0);
      chk("arst_pix_color", pix_color, 0);
      chk("arst_pix_hit", pix_hit, 0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      m_vb = 0; m_sen = 0; m_sx = 0; m_sy = 0;
      q.delete();
      for (int i = 0; i < 4; i++) idle();
      probe(250, 0, 1'b0, "arst_no_draw");
      ld_valid = 1'b0;
      vblank(3);
      probe(250, 0, 1'b1, "arst_redraw");

      // randomized frames against the model
      for (int f = 0; f < 8; f++) begin
         int sx, sy, nw;
         sx = int'($urandom_range(0, 255));
         sy = int'($urandom_range(0, 239));
         card_x  = 8'(sx);
         card_y  = 8'(sy);
         card_en = ($urandom_range(0, 3) != 0);
         nw = int'($urandom_range(0, 12));
         for (int i = 0; i < nw; i++)
            wq.push_back('{int'($urandom_range(0, 511)), int'($urandom_range(0, 7))});
         vblank(10);
         ld_valid = 1'($urandom_range(0, 1));
         ld_addr  = 9'($urandom);
         ld_data  = 3'($urandom);
         for (int i = 0; i < 250; i++) begin
            int hc, vc;
            hc = sx + int'($urandom_range(0, 23)) - 4;
            vc = sy + int'($urandom_range(0, 39)) - 4;
            if (hc < 0) hc = 0;
            if (vc < 0) vc = 0;
            if (vc > 239) vc = 239;
            set_px(hc, vc, hc < 256 && $urandom_range(0, 7) != 0);
            cyc();
         end
         ld_valid = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
